calc_sequencer: RTL
===================

Name: calc_sequencer

Overview:
- Compute engine directly upstream of the HPS-readable register snapshot block.
- Accepts operands a/b and an opcode on a start strobe, then runs ADD/SUB in one execute cycle and MUL/DIV/MOD as 16-cycle iterative shift-add / restoring-divide loops.
- On completion, presents a, b, op_code, r and status together and pulses writeEnable for exactly one cycle, so the downstream register block captures a coherent snapshot.

Parameters:
- WIDTH, 16, operand/result width. All arithmetic rules below are stated for 16; iteration count = WIDTH.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- a_in  input  16  operand a
- b_in  input  16  operand b
- op_code_in  input  16  opcode; only [2:0] is decoded, and [15:3] must be 0 or the opcode is invalid
- busy  output  1  high from the capture edge until WRITE exits
- a  output  16  latched operand a, to the register block
- b  output  16  latched operand b
- op_code  output  16  latched opcode
- r  output  16  result
- status  output  16  status flags
- writeEnable  output  1  one-cycle snapshot strobe to the register block

Behaviour:
- Reset (rst=1 at an edge) forces state IDLE and sets busy, a, b, op_code, r, status and writeEnable to 0.
  - Reset overrides everything, including mid-iteration.
  - An aborted operation never asserts writeEnable.
- States: IDLE, EXEC, WRITE.
- IDLE:
  - start=1 at edge E0 latches a_in/b_in/op_code_in into a/b/op_code, clears the internal accumulator and counter, sets busy=1, and moves to EXEC.
  - start=0 holds IDLE.
- EXEC, single-cycle cases: ADD(0), SUB(1), invalid opcode, and DIV/MOD with b=0. These compute in the cycle after E0 and move to WRITE at E1.
- EXEC, MUL(2)/DIV(3)/MOD(4) with a valid divisor:
  - Counter runs 0..15, one partial-product or quotient bit per cycle.
  - Moves to WRITE at E16.
- WRITE:
  - At entry, r and status are loaded from internal results.
  - writeEnable=1 for exactly one cycle (E1..E2 or E16..E17), so downstream captures at E2 or E17.
  - Next edge: back to IDLE, with busy=0 and writeEnable=0.
- Opcodes 5-7 and any nonzero op_code_in[15:3] are invalid.
- Arithmetic (unsigned, 16-bit):
  - ADD: r = (a+b)[15:0]; status[1] = carry out.
  - SUB: r = (a-b)[15:0]; status[1] = borrow (a<b).
  - MUL: r = low 16 bits of the 32-bit product; status[1] = (high 16 bits ≠ 0).
  - DIV: r = a/b.
  - MOD: r = a%b.
  - b=0 for DIV/MOD: r = 0, status[2] = 1.
  - Invalid opcode: r = 0, status[3] = 1.
- status bits:
  - [0] valid: 1 on every completed WRITE
  - [1] carry/borrow/overflow
  - [2] divide-by-zero
  - [3] invalid opcode
  - [4] zero: r==0, after the rules above
  - [15:5] = 0
- Output hold:
  - a/b/op_code change only at a capture edge.
  - r/status change only at WRITE entry or reset.
  - Internal accumulators are never exposed on r mid-iteration.
- start while busy is ignored; there is no queueing.
- start held high continuously re-triggers from IDLE one cycle after each WRITE.
- start and rst high on the same edge: reset wins.

Test Plan:
1. ADD: a=0x1234, b=0x0001, op=0, start at E0. Expect writeEnable=1 only between E1 and E2, r=0x1235, status=0x0001, busy low after E2.
2. ADD/SUB carry and borrow:
   - 0xFFFF+0x0002 → r=0x0001, status=0x0003.
   - 0x0003-0x0005 → r=0xFFFE, status=0x0003.
   - 0x0005-0x0005 → r=0x0000, status=0x0011.
3. MUL:
   - 0x00FF*0x0101 → r=0xFFFF, status=0x0001, writeEnable exactly at E16..E17.
   - 0x0100*0x0100 → r=0x0000, status=0x0013.
4. DIV/MOD:
   - 100/7 → r=14, status=0x0001.
   - 100%7 → r=2.
   - 0x0005/0x0000 → r=0, status=0x0015, completes at E1 (single cycle).
   - Invalid op=0x0009 → r=0, status=0x0019.
5. Handshake: start pulsed again at E5 during MUL → ignored, a/b/op_code unchanged, exactly one writeEnable pulse. Then assert rst at E8 of a second MUL → all outputs 0, no writeEnable ever appears, and a fresh ADD afterwards completes normally.

Source files
------------

// File: rtl/calc_sequencer.sv
// Operand-capture / compute / snapshot sequencer feeding the HPS register block.
// ADD/SUB finish in one execute cycle; MUL/DIV/MOD iterate one bit per cycle.
module calc_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] op_code_in,
    output logic             busy,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] op_code,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] status,
    output logic             writeEnable
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned DW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [DW-1:0]    acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-2:0] quo;
    logic [CNT_W-1:0] cnt;

    logic [2:0]       op_sel_c;
    logic             valid_op_c;
    logic             single_c;
    logic             capture_c;
    logic             step_c;
    logic             done_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [DW-1:0]    acc_nxt_c;
    logic [WIDTH:0]   rem_sh_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_nxt_c;
    logic [WIDTH-1:0] quo_nxt_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             dz_c;
    logic             inv_c;
    logic [WIDTH-1:0] status_c;

    // Opcode decode and per-cycle arithmetic (shift-add multiply, restoring divide)
    always_comb begin
        op_sel_c   = op_code[2:0];
        valid_op_c = (op_code[WIDTH-1:3] == '0) && (op_sel_c <= 3'd4);
        single_c   = !valid_op_c || (op_sel_c < 3'd2) || ((op_sel_c != 3'd2) && (b == '0));
        sum_c      = {1'b0, a} + {1'b0, b};
        diff_c     = {1'b0, a} - {1'b0, b};
        acc_nxt_c  = acc + (b[cnt] ? ({{WIDTH{1'b0}}, a} << cnt) : '0);
        rem_sh_c   = {rem, a[LAST - cnt]};
        ge_c       = rem_sh_c >= {1'b0, b};
        rem_nxt_c  = ge_c ? WIDTH'(rem_sh_c - {1'b0, b}) : rem_sh_c[WIDTH-1:0];
        quo_nxt_c  = {quo, ge_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = EXEC;
            EXEC:    if (done_c) next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control strobes and the result/status that WRITE entry will load
    always_comb begin
        capture_c = (state == IDLE) && start;
        step_c    = (state == EXEC) && !single_c;
        done_c    = (state == EXEC) && (single_c || (cnt == LAST));
        res_c     = '0;
        carry_c   = 1'b0;
        dz_c      = 1'b0;
        inv_c     = 1'b0;
        if (!valid_op_c) begin
            inv_c = 1'b1;
        end else begin
            case (op_sel_c)
                3'd0: begin
                    res_c   = sum_c[WIDTH-1:0];
                    carry_c = sum_c[WIDTH];
                end
                3'd1: begin
                    res_c   = diff_c[WIDTH-1:0];
                    carry_c = diff_c[WIDTH];
                end
                3'd2: begin
                    res_c   = acc_nxt_c[WIDTH-1:0];
                    carry_c = |acc_nxt_c[DW-1:WIDTH];
                end
                3'd3: begin
                    if (b == '0) dz_c = 1'b1;
                    else         res_c = quo_nxt_c;
                end
                3'd4: begin
                    if (b == '0) dz_c = 1'b1;
                    else         res_c = rem_nxt_c;
                end
                default: inv_c = 1'b1;
            endcase
        end
        status_c = {{(WIDTH-5){1'b0}}, (res_c == '0), inv_c, dz_c, carry_c, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            a           <= '0;
            b           <= '0;
            op_code     <= '0;
            r           <= '0;
            status      <= '0;
            writeEnable <= 1'b0;
            acc         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
        end else begin
            busy        <= (next_state != IDLE);
            writeEnable <= done_c;
            if (capture_c) begin
                a       <= a_in;
                b       <= b_in;
                op_code <= op_code_in;
                acc     <= '0;
                rem     <= '0;
                quo     <= '0;
                cnt     <= '0;
            end
            if (step_c) begin
                acc <= acc_nxt_c;
                rem <= rem_nxt_c;
                quo <= quo_nxt_c[WIDTH-2:0];
                cnt <= cnt + 1'b1;
            end
            // r/status only ever change here, so iteration state is never visible
            if (done_c) begin
                r      <= res_c;
                status <= status_c;
            end
        end
    end

endmodule
